dbus_mem_arbiter: RTL and testbench

// - Shares the data port of the VexRiscv program/data RAM between two masters: CPU dBus (req 0)
//   and an auxiliary master (req 1, e.g. UART loader / DMA). Sits between the dBus word-address

---
 rtl/dbus_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dbus_mem_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_mem_arbiter.sv
// dbus_mem_arbiter
// Shares the VexRiscv program/data RAM data port between the CPU dBus (requester 0)
// and an auxiliary master such as a UART loader or DMA (requester 1).
// The grant is decided in the same cycle as the request. Read data comes back one cycle
// after acceptance and is steered to the master that issued the read.
//
// Build option ARB_ROUND_ROBIN_EN:
//   defined   - on contention the master not granted last wins (rr_last)
//   undefined - CPU wins contention; aux is forced through after MAX_WAIT lost cycles
//
// state      | meaning
// lock_q     | aux holds the port for a burst; the CPU is kept off the port
// wait_cnt   | consecutive cycles aux has waited without a grant (fixed-priority build)
// rr_last    | master granted most recently (round-robin build)
// rd_pending | a read was accepted last cycle; rd_owner records which master issued it
module dbus_mem_arbiter #(
   parameter int WL       = 32,
   parameter int ADDR_WL  = 13,
   parameter int MAX_WAIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_cmd_valid,
   output logic                 cpu_cmd_ready,
   input  logic                 cpu_cmd_wr,
   input  logic [ADDR_WL-1:0]   cpu_cmd_addr,
   input  logic [WL/8-1:0]      cpu_cmd_be,
   input  logic [WL-1:0]        cpu_cmd_wdata,
   output logic                 cpu_rsp_valid,
   output logic [WL-1:0]        cpu_rsp_data,
   input  logic                 aux_cmd_valid,
   output logic                 aux_cmd_ready,
   input  logic                 aux_cmd_wr,
   input  logic [ADDR_WL-1:0]   aux_cmd_addr,
   input  logic [WL/8-1:0]      aux_cmd_be,
   input  logic [WL-1:0]        aux_cmd_wdata,
   input  logic                 aux_lock,
   output logic                 aux_rsp_valid,
   output logic [WL-1:0]        aux_rsp_data,
   output logic [WL/8-1:0]      mem_we,
   output logic [ADDR_WL-1:0]   mem_addr,
   output logic [WL-1:0]        mem_din,
   input  logic [WL-1:0]        mem_dout
);

   localparam int   BW      = WL / 8;
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_AUX = 1'b1;

   logic                lock_q;
   logic                rd_pending;
   logic                rd_owner;
   logic                aux_wins_tie;
   logic                gnt_cpu;
   logic                gnt_aux;
   logic                any_gnt;
   logic                win_wr;
   logic [BW-1:0]       win_be;
   logic [ADDR_WL-1:0]  win_addr;
   logic [WL-1:0]       win_wdata;
   logic [ADDR_WL-1:0]  addr_q;
   logic [WL-1:0]       din_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_last;

   // Contention goes to whichever master did not win most recently.
   assign aux_wins_tie = (rr_last == OWN_CPU);

   // Remember the most recent winner; idle cycles leave it untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last <= OWN_AUX;
      end else if (gnt_aux) begin
         rr_last <= OWN_AUX;
      end else if (gnt_cpu) begin
         rr_last <= OWN_CPU;
      end
   end
`else
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   logic [7:0] wait_cnt;

   // CPU wins contention until aux has lost MAX_WAIT cycles in a row.
   assign aux_wins_tie = (wait_cnt == WAIT_LIMIT);

   // Count consecutive aux losses, saturating; any aux grant or aux idle restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!aux_cmd_valid || gnt_aux) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`endif

   // Single-cycle grant; nothing is granted while reset is asserted.
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_aux = 1'b0;
      if (!reset) begin
         if (lock_q) begin
            gnt_aux = aux_cmd_valid;
         end else if (cpu_cmd_valid && aux_cmd_valid) begin
            gnt_aux = aux_wins_tie;
            gnt_cpu = !aux_wins_tie;
         end else begin
            gnt_cpu = cpu_cmd_valid;
            gnt_aux = aux_cmd_valid;
         end
      end
   end

   assign cpu_cmd_ready = gnt_cpu;
   assign aux_cmd_ready = gnt_aux;
   assign any_gnt       = gnt_cpu | gnt_aux;

   // Select the winning master's command for the memory side.
   always_comb begin
      win_wr    = cpu_cmd_wr;
      win_be    = cpu_cmd_be;
      win_addr  = cpu_cmd_addr;
      win_wdata = cpu_cmd_wdata;
      if (gnt_aux) begin
         win_wr    = aux_cmd_wr;
         win_be    = aux_cmd_be;
         win_addr  = aux_cmd_addr;
         win_wdata = aux_cmd_wdata;
      end
   end

   // Write enables only ever come from a granted write; address and data hold when idle.
   assign mem_we   = any_gnt ? (win_be & {BW{win_wr}}) : '0;
   assign mem_addr = any_gnt ? win_addr : addr_q;
   assign mem_din  = any_gnt ? win_wdata : din_q;

   // Keep the last driven address/data so the RAM inputs stay quiet between accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         din_q  <= '0;
      end else if (any_gnt) begin
         addr_q <= win_addr;
         din_q  <= win_wdata;
      end
   end

   // Aux burst lock: taken on a locked aux grant, released as soon as aux_lock drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q <= 1'b0;
      end else if (gnt_aux && aux_lock) begin
         lock_q <= 1'b1;
      end else if (!aux_lock) begin
         lock_q <= 1'b0;
      end
   end

   // Track the read accepted last cycle so its data can be routed to the issuer.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pending <= 1'b0;
         rd_owner   <= OWN_CPU;
      end else begin
         rd_pending <= any_gnt && !win_wr;
         rd_owner   <= gnt_aux ? OWN_AUX : OWN_CPU;
      end
   end

   // A response due in a reset cycle is dropped rather than delivered.
   assign cpu_rsp_valid = rd_pending && (rd_owner == OWN_CPU) && !reset;
   assign aux_rsp_valid = rd_pending && (rd_owner == OWN_AUX) && !reset;
   assign cpu_rsp_data  = mem_dout;
   assign aux_rsp_data  = mem_dout;

endmodule

// File: tb/tb_dbus_mem_arbiter.sv
// Testbench for dbus_mem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model and a behavioural RAM.
module tb_dbus_mem_arbiter;

   localparam int WL       = 32;
   localparam int ADDR_WL  = 13;
   localparam int MAX_WAIT = 16;
   localparam int BW       = WL / 8;
   localparam int DEPTH    = 1 << ADDR_WL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic                cpu_cmd_valid, cpu_cmd_ready, cpu_cmd_wr;
   logic [ADDR_WL-1:0]  cpu_cmd_addr;
   logic [BW-1:0]       cpu_cmd_be;
   logic [WL-1:0]       cpu_cmd_wdata;
   logic                cpu_rsp_valid;
   logic [WL-1:0]       cpu_rsp_data;
   logic                aux_cmd_valid, aux_cmd_ready, aux_cmd_wr;
   logic [ADDR_WL-1:0]  aux_cmd_addr;
   logic [BW-1:0]       aux_cmd_be;
   logic [WL-1:0]       aux_cmd_wdata;
   logic                aux_lock;
   logic                aux_rsp_valid;
   logic [WL-1:0]       aux_rsp_data;
   logic [BW-1:0]       mem_we;
   logic [ADDR_WL-1:0]  mem_addr;
   logic [WL-1:0]       mem_din;
   logic [WL-1:0]       mem_dout;

   logic [WL-1:0] ram     [DEPTH];
   logic [WL-1:0] ref_mem [DEPTH];

   int total;
   int bad;

   // reference model state
   bit            m_locked;
   bit            m_last_aux;
   bit            m_pend;
   bit            m_pend_aux;
   int            m_wait;
   logic [WL-1:0] m_pend_data;

   dbus_mem_arbiter #(.WL(WL), .ADDR_WL(ADDR_WL), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
      .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_be(cpu_cmd_be), .cpu_cmd_wdata(cpu_cmd_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
      .aux_cmd_valid(aux_cmd_valid), .aux_cmd_ready(aux_cmd_ready), .aux_cmd_wr(aux_cmd_wr),
      .aux_cmd_addr(aux_cmd_addr), .aux_cmd_be(aux_cmd_be), .aux_cmd_wdata(aux_cmd_wdata),
      .aux_lock(aux_lock), .aux_rsp_valid(aux_rsp_valid), .aux_rsp_data(aux_rsp_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   function automatic logic [WL-1:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // behavioural RAM: 1-cycle read latency, read-before-write, byte enables
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
      forever begin
         @(posedge clk);
         mem_dout <= ram[mem_addr];
         for (int b = 0; b < BW; b++)
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Who should win this cycle, from the arbitration rules and model state.
   function automatic void exp_grant(output bit gc, output bit ga);
      gc = 1'b0;
      ga = 1'b0;
      if (reset !== 1'b1) begin
         if (m_locked) begin
            ga = aux_cmd_valid;
         end else if (cpu_cmd_valid && aux_cmd_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            ga = !m_last_aux;
`else
            ga = (m_wait >= MAX_WAIT);
`endif
            gc = !ga;
         end else begin
            gc = cpu_cmd_valid;
            ga = aux_cmd_valid;
         end
      end
   endfunction

   task automatic model_commit();
      bit gc, ga;
      exp_grant(gc, ga);
      if (reset) begin
         m_wait     = 0;
         m_locked   = 1'b0;
         m_last_aux = 1'b1;
         m_pend     = 1'b0;
      end else begin
         m_pend     = (gc && !cpu_cmd_wr) || (ga && !aux_cmd_wr);
         m_pend_aux = ga;
         if (gc) begin
            if (cpu_cmd_wr) begin
               for (int b = 0; b < BW; b++)
                  if (cpu_cmd_be[b]) ref_mem[cpu_cmd_addr][8*b +: 8] = cpu_cmd_wdata[8*b +: 8];
            end else begin
               m_pend_data = ref_mem[cpu_cmd_addr];
            end
         end
         if (ga) begin
            if (aux_cmd_wr) begin
               for (int b = 0; b < BW; b++)
                  if (aux_cmd_be[b]) ref_mem[aux_cmd_addr][8*b +: 8] = aux_cmd_wdata[8*b +: 8];
            end else begin
               m_pend_data = ref_mem[aux_cmd_addr];
            end
         end
         if (ga || !aux_cmd_valid) m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
         if (ga && aux_lock) m_locked = 1'b1;
         else if (!aux_lock) m_locked = 1'b0;
         if (ga) m_last_aux = 1'b1;
         else if (gc) m_last_aux = 1'b0;
      end
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      cpu_cmd_valid = 1'b0; cpu_cmd_wr = 1'b0; cpu_cmd_addr = '0; cpu_cmd_be = '0; cpu_cmd_wdata = '0;
      aux_cmd_valid = 1'b0; aux_cmd_wr = 1'b0; aux_cmd_addr = '0; aux_cmd_be = '0; aux_cmd_wdata = '0;
      aux_lock = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_cmd_valid = 1'b1; cpu_cmd_wr = 1'b1; cpu_cmd_be = 4'hF;
      aux_cmd_valid = 1'b1; aux_cmd_wr = 1'b1; aux_cmd_be = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (cpu_cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cpu_ready got=%b exp=0", cpu_cmd_ready); end
         total++; if (aux_cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_aux_ready got=%b exp=0", aux_cmd_ready); end
         total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
         total++; if (cpu_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_cpu_rsp got=%b exp=0", cpu_rsp_valid); end
         total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_aux_rsp got=%b exp=0", aux_rsp_valid); end
         tick();
      end
      set_idle();
      reset = 1'b0;
      #1;
      total++; if (cpu_rsp_valid !== 1'b0 || aux_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL post_rst_rsp got=%b%b exp=00", cpu_rsp_valid, aux_rsp_valid);
      end
      tick();
   endtask

   task automatic test_cpu_write_read();
      set_idle();
      cpu_cmd_valid = 1'b1; cpu_cmd_wr = 1'b1; cpu_cmd_addr = 13'h010; cpu_cmd_be = 4'b1111;
      cpu_cmd_wdata = 32'hDEADBEEF;
      #1;
      total++; if (cpu_cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_cpu_ready got=%b exp=1", cpu_cmd_ready); end
      total++; if (mem_we !== 4'hF) begin bad++; $display("FAIL wr_mem_we got=%h exp=f", mem_we); end
      total++; if (mem_addr !== 13'h010) begin bad++; $display("FAIL wr_mem_addr got=%h exp=010", mem_addr); end
      total++; if (mem_din !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem_din got=%h exp=deadbeef", mem_din); end
      tick();
      cpu_cmd_wr = 1'b0; cpu_cmd_be = 4'h0;
      #1;
      total++; if (cpu_cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_cpu_ready got=%b exp=1", cpu_cmd_ready); end
      total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL rd_mem_we got=%h exp=0", mem_we); end
      tick();
      set_idle();
      #1;
      total++; if (cpu_rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_cpu_rsp_valid got=%b exp=1", cpu_rsp_valid); end
      total++; if (cpu_rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_cpu_rsp_data got=%h exp=deadbeef", cpu_rsp_data); end
      total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_aux_rsp_valid got=%b exp=0", aux_rsp_valid); end
      total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL idle_mem_we got=%h exp=0", mem_we); end
      total++; if (mem_addr !== 13'h010) begin bad++; $display("FAIL idle_mem_addr_hold got=%h exp=010", mem_addr); end
      tick();
   endtask

   task automatic test_starvation();
      bit ea, pa;
      set_idle();
      cpu_cmd_valid = 1'b1; cpu_cmd_addr = 13'h020;
      aux_cmd_valid = 1'b1; aux_cmd_addr = 13'h030;
      for (int k = 1; k <= 40; k++) begin
         ea = (k == 17) || (k == 34);
         pa = (k == 18) || (k == 35);
         #1;
         total++; if (aux_cmd_ready !== ea) begin bad++; $display("FAIL starve_aux_ready cyc=%0d got=%b exp=%b", k, aux_cmd_ready, ea); end
         total++; if (cpu_cmd_ready !== !ea) begin bad++; $display("FAIL starve_cpu_ready cyc=%0d got=%b exp=%b", k, cpu_cmd_ready, !ea); end
         if (k > 1) begin
            total++; if (aux_rsp_valid !== pa) begin bad++; $display("FAIL starve_aux_rsp cyc=%0d got=%b exp=%b", k, aux_rsp_valid, pa); end
            total++; if (cpu_rsp_valid !== !pa) begin bad++; $display("FAIL starve_cpu_rsp cyc=%0d got=%b exp=%b", k, cpu_rsp_valid, !pa); end
            if (pa) begin
               total++; if (aux_rsp_data !== init_word(32'h30)) begin bad++; $display("FAIL starve_aux_data got=%h exp=%h", aux_rsp_data, init_word(32'h30)); end
            end else begin
               total++; if (cpu_rsp_data !== init_word(32'h20)) begin bad++; $display("FAIL starve_cpu_data got=%h exp=%h", cpu_rsp_data, init_word(32'h20)); end
            end
         end
         tick();
      end
      set_idle();
      tick();
   endtask

   task automatic test_lock_burst();
      bit gap;
      int w;
      set_idle();
      for (int j = 0; j < 9; j++) begin
         gap = (j == 4);
         w   = (j < 4) ? j : j - 1;
         aux_cmd_valid = !gap; aux_cmd_wr = 1'b1; aux_cmd_addr = 13'(w); aux_cmd_be = 4'hF;
         aux_cmd_wdata = 32'h0000_1000 + 32'(w);
         aux_lock      = (j < 8);
         cpu_cmd_valid = (j > 0); cpu_cmd_wr = 1'b0; cpu_cmd_addr = 13'h040;
         #1;
         total++; if (cpu_cmd_ready !== 1'b0) begin bad++; $display("FAIL lock_cpu_ready cyc=%0d got=%b exp=0", j, cpu_cmd_ready); end
         total++; if (aux_cmd_ready !== !gap) begin bad++; $display("FAIL lock_aux_ready cyc=%0d got=%b exp=%b", j, aux_cmd_ready, !gap); end
         total++; if (mem_we !== (gap ? 4'h0 : 4'hF)) begin bad++; $display("FAIL lock_mem_we cyc=%0d got=%h exp=%h", j, mem_we, gap ? 4'h0 : 4'hF); end
         total++; if (mem_addr !== (gap ? 13'd3 : 13'(w))) begin bad++; $display("FAIL lock_mem_addr cyc=%0d got=%h exp=%h", j, mem_addr, gap ? 13'd3 : 13'(w)); end
         tick();
      end
      aux_cmd_valid = 1'b0; aux_cmd_wr = 1'b0; aux_lock = 1'b0;
      #1;
      total++; if (cpu_cmd_ready !== 1'b1) begin bad++; $display("FAIL unlock_cpu_ready got=%b exp=1", cpu_cmd_ready); end
      tick();
      set_idle();
      #1;
      total++; if (cpu_rsp_valid !== 1'b1) begin bad++; $display("FAIL unlock_cpu_rsp got=%b exp=1", cpu_rsp_valid); end
      total++; if (cpu_rsp_data !== init_word(32'h40)) begin bad++; $display("FAIL unlock_cpu_data got=%h exp=%h", cpu_rsp_data, init_word(32'h40)); end
      tick();
   endtask

   task automatic test_alternating();
      bit is_aux, prev_aux;
      logic [WL-1:0] exp_d;
      set_idle();
      for (int k = 0; k < 9; k++) begin
         is_aux   = (k % 2 == 1);
         prev_aux = ((k - 1) % 2 == 1);
         if (k < 8) begin
            cpu_cmd_valid = !is_aux; cpu_cmd_addr = 13'h001;
            aux_cmd_valid = is_aux;  aux_cmd_addr = 13'h002;
         end else begin
            set_idle();
         end
         #1;
         if (k < 8) begin
            total++; if (cpu_cmd_ready !== !is_aux || aux_cmd_ready !== is_aux) begin
               bad++; $display("FAIL alt_ready cyc=%0d got=%b%b exp=%b%b", k, cpu_cmd_ready, aux_cmd_ready, !is_aux, is_aux);
            end
         end
         if (k > 0) begin
            exp_d = prev_aux ? ref_mem[2] : ref_mem[1];
            total++; if (aux_rsp_valid !== prev_aux || cpu_rsp_valid !== !prev_aux) begin
               bad++; $display("FAIL alt_rsp_valid cyc=%0d got=%b%b exp=%b%b", k, cpu_rsp_valid, aux_rsp_valid, !prev_aux, prev_aux);
            end
            total++; if ((prev_aux ? aux_rsp_data : cpu_rsp_data) !== exp_d) begin
               bad++; $display("FAIL alt_rsp_data cyc=%0d got=%h exp=%h", k, prev_aux ? aux_rsp_data : cpu_rsp_data, exp_d);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_read();
      set_idle();
      aux_cmd_valid = 1'b1; aux_cmd_addr = 13'h005; aux_lock = 1'b1;
      #1;
      total++; if (aux_cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_aux_ready got=%b exp=1", aux_cmd_ready); end
      tick();
      reset = 1'b1;
      cpu_cmd_valid = 1'b1; cpu_cmd_addr = 13'h020;
      #1;
      total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_aux_rsp_in_reset got=%b exp=0", aux_rsp_valid); end
      total++; if (cpu_cmd_ready !== 1'b0 || aux_cmd_ready !== 1'b0) begin
         bad++; $display("FAIL mid_ready_in_reset got=%b%b exp=00", cpu_cmd_ready, aux_cmd_ready);
      end
      total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL mid_mem_we_in_reset got=%h exp=0", mem_we); end
      tick();
      reset = 1'b0; aux_lock = 1'b0;
      #1;
      total++; if (aux_rsp_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL mid_rsp_after_reset got=%b%b exp=00", cpu_rsp_valid, aux_rsp_valid);
      end
      total++; if (cpu_cmd_ready !== 1'b1 || aux_cmd_ready !== 1'b0) begin
         bad++; $display("FAIL mid_lock_cleared got=%b%b exp=10", cpu_cmd_ready, aux_cmd_ready);
      end
      tick();
      set_idle();
      tick();
`ifndef ARB_ROUND_ROBIN_EN
      cpu_cmd_valid = 1'b1; cpu_cmd_addr = 13'h020;
      aux_cmd_valid = 1'b1; aux_cmd_addr = 13'h030;
      for (int k = 0; k < 12; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         total++; if (cpu_cmd_ready !== 1'b1 || aux_cmd_ready !== 1'b0) begin
            bad++; $display("FAIL wait_cleared_by_reset cyc=%0d got=%b%b exp=10", k, cpu_cmd_ready, aux_cmd_ready);
         end
         tick();
      end
      set_idle();
      tick();
`endif
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   task automatic test_round_robin();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cpu_cmd_valid = 1'b1; cpu_cmd_addr = 13'h020;
      aux_cmd_valid = 1'b1; aux_cmd_addr = 13'h030;
      for (int k = 0; k < 10; k++) begin
         #1;
         total++; if (cpu_cmd_ready !== (k % 2 == 0) || aux_cmd_ready !== (k % 2 == 1)) begin
            bad++; $display("FAIL rr_alternate cyc=%0d got=%b%b exp=%b%b", k, cpu_cmd_ready, aux_cmd_ready, k % 2 == 0, k % 2 == 1);
         end
         tick();
      end
      set_idle();
      tick();
   endtask
`endif

   task automatic test_random();
      bit gc, ga, ecv, eav;
      logic [BW-1:0] ewe;
      for (int n = 0; n < 500; n++) begin
         reset         = ($urandom_range(0, 49) == 0);
         cpu_cmd_valid = ($urandom_range(0, 9) < 7);
         cpu_cmd_wr    = 1'($urandom_range(0, 1));
         cpu_cmd_addr  = 13'($urandom_range(0, 15));
         cpu_cmd_be    = 4'($urandom);
         cpu_cmd_wdata = $urandom;
         aux_cmd_valid = ($urandom_range(0, 9) < 7);
         aux_cmd_wr    = 1'($urandom_range(0, 1));
         aux_cmd_addr  = 13'($urandom_range(0, 15));
         aux_cmd_be    = 4'($urandom);
         aux_cmd_wdata = $urandom;
         aux_lock      = ($urandom_range(0, 9) < 3);
         #1;
         exp_grant(gc, ga);
         ewe = gc ? (cpu_cmd_wr ? cpu_cmd_be : 4'h0) : ga ? (aux_cmd_wr ? aux_cmd_be : 4'h0) : 4'h0;
         ecv = m_pend && !m_pend_aux && !reset;
         eav = m_pend && m_pend_aux && !reset;
         total++; if (cpu_cmd_ready !== gc || aux_cmd_ready !== ga) begin
            bad++; $display("FAIL rnd_grant n=%0d got=%b%b exp=%b%b", n, cpu_cmd_ready, aux_cmd_ready, gc, ga);
         end
         total++; if (mem_we !== ewe) begin bad++; $display("FAIL rnd_mem_we n=%0d got=%h exp=%h", n, mem_we, ewe); end
         if (gc || ga) begin
            total++; if (mem_addr !== (gc ? cpu_cmd_addr : aux_cmd_addr)) begin
               bad++; $display("FAIL rnd_mem_addr n=%0d got=%h exp=%h", n, mem_addr, gc ? cpu_cmd_addr : aux_cmd_addr);
            end
            total++; if (mem_din !== (gc ? cpu_cmd_wdata : aux_cmd_wdata)) begin
               bad++; $display("FAIL rnd_mem_din n=%0d got=%h exp=%h", n, mem_din, gc ? cpu_cmd_wdata : aux_cmd_wdata);
            end
         end
         total++; if (cpu_rsp_valid !== ecv || aux_rsp_valid !== eav) begin
            bad++; $display("FAIL rnd_rsp_valid n=%0d got=%b%b exp=%b%b", n, cpu_rsp_valid, aux_rsp_valid, ecv, eav);
         end
         if (ecv) begin
            total++; if (cpu_rsp_data !== m_pend_data) begin bad++; $display("FAIL rnd_cpu_data n=%0d got=%h exp=%h", n, cpu_rsp_data, m_pend_data); end
         end
         if (eav) begin
            total++; if (aux_rsp_data !== m_pend_data) begin bad++; $display("FAIL rnd_aux_data n=%0d got=%h exp=%h", n, aux_rsp_data, m_pend_data); end
         end
         tick();
      end
      reset = 1'b0;
      set_idle();
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_wait = 0; m_locked = 1'b0; m_last_aux = 1'b1; m_pend = 1'b0; m_pend_aux = 1'b0; m_pend_data = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      reset = 1'b1;
      set_idle();
      @(negedge clk);
      test_reset();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
`endif
      test_cpu_write_read();
`ifndef ARB_ROUND_ROBIN_EN
      test_starvation();
`endif
      test_lock_burst();
      test_alternating();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
